// File: rtl/rx_framer_pkg.sv
// rx_framer_pkg: shared definitions for the RX framer slice.
//   - slot tag values carried on the deserialiser tag bus
//   - framer FSM state encoding
//   - header word bit-field offsets
//   - CRC-16/CCITT constants and helpers that the CRC sub-module uses
//     to derive its XOR matrix at elaboration time
// Ports: none (package).
package rx_framer_pkg;

   localparam logic [3:0] TAG_HEADER  = 4'd2;
   localparam logic [3:0] TAG_TS_MSB  = 4'd4;
   localparam logic [3:0] TAG_TS_LSB  = 4'd6;
   localparam logic [3:0] TAG_FCS     = 4'd8;
   localparam logic [3:0] TAG_PAYLOAD = 4'd15;

   typedef enum logic [2:0] {
      ST_HEADER  = 3'd0,
      ST_TS_MSB  = 3'd1,
      ST_TS_LSB  = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_FCS     = 3'd4
   } state_t;

   // Header word: {sync[31:16], ovf[15], err[14], channel[13:12], seq[11:0]}
   localparam int HDR_SEQ_LSB  = 0;
   localparam int HDR_SEQ_W    = 12;
   localparam int HDR_CH_LSB   = 12;
   localparam int HDR_ERR_BIT  = 14;
   localparam int HDR_OVF_BIT  = 15;
   localparam int HDR_SYNC_LSB = 16;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // Bit-serial CRC-16/CCITT over one 32-bit word, MSB first.
   function automatic logic [15:0] crc16_word(input logic [15:0] c_in, input logic [31:0] d);
      logic [15:0] c;
      logic        fb;
      c = c_in;
      for (int i = 31; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
      return c;
   endfunction

   // The word update is linear over GF(2), so each output bit is the parity
   // of a fixed subset of {crc_in, data}. Probe with unit vectors to find it.
   function automatic logic [47:0] crc16_bit_mask(input int bit_idx);
      logic [47:0] unit_vec;
      logic [47:0] mask;
      logic [15:0] r;
      mask = '0;
      for (int j = 0; j < 48; j++) begin
         unit_vec = 48'd1 << j;
         r        = crc16_word(unit_vec[47:32], unit_vec[31:0]);
         mask[j]  = r[bit_idx[3:0]];
      end
      return mask;
   endfunction

endpackage

// File: rtl/crc16_d32.sv
// crc16_d32: combinational next-CRC for CRC-16/CCITT (poly 0x1021),
// one 32-bit word per step, MSB first. Only present in builds that define
// RX_FRAMER_CRC_EN; otherwise this file elaborates to nothing.
// Ports:
//   crc_in  [15:0] current CRC
//   data    [31:0] payload word
//   crc_out [15:0] CRC after absorbing data
`ifdef RX_FRAMER_CRC_EN
module crc16_d32
   import rx_framer_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [31:0] data,
   output logic [15:0] crc_out
);

   logic [47:0] state_vec;

   assign state_vec = {crc_in, data};

   // One parity tree per output bit; masks are fixed at elaboration.
   for (genvar gi = 0; gi < 16; gi++) begin : g_out
      localparam logic [47:0] MASK = crc16_bit_mask(gi);
      assign crc_out[gi] = ^(state_vec & MASK);
   end

endmodule
`endif

// File: rtl/rx_framer_pkt.sv
// rx_framer_pkt: packs the tag-sequenced RX sample stream into frames
// (header, 64-bit timestamp, NB_SAMPLES payload words, FCS) for the RX FIFO.
// Optional build macro: RX_FRAMER_CRC_EN -- when defined the FCS word carries
// a CRC-16/CCITT over the payload; otherwise it carries NB_SAMPLES.
// Ports:
//   i_clk, i_reset_n (async, active low)
//   i_enable       allows a new frame to start (running frames always finish)
//   i_data_tag/i_data  slot tag and sample from the deserialiser
//   i_fifo_full    RX FIFO back-pressure
//   o_fifo_push/o_fifo_data  one registered word per push, 1-cycle latency
//   o_led          toggles per completed frame
//   o_busy         high while a frame is in progress
//   o_drop_cnt     frames aborted by overflow (saturating)
//   o_err_cnt      frames aborted by sequence error (saturating)
module rx_framer_pkt
   import rx_framer_pkg::*;
#(
   parameter int          NB_SAMPLES         = 256,
   parameter int          TIMESTAMP_ACCURACY = 250,
   parameter int          CHANNEL_ID         = 0,
   parameter logic [15:0] SYNC_WORD          = 16'hCAFE,
   parameter logic [15:0] FCS_WORD           = 16'hC0DE
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_enable,
   input  logic [3:0]  i_data_tag,
   input  logic [31:0] i_data,
   input  logic        i_fifo_full,
   output logic        o_fifo_push,
   output logic [31:0] o_fifo_data,
   output logic        o_led,
   output logic        o_busy,
   output logic [15:0] o_drop_cnt,
   output logic [15:0] o_err_cnt
);

   localparam logic [9:0]  CNT_LAST     = 10'(NB_SAMPLES - 1);
   localparam logic [9:0]  NB_LEN       = 10'(NB_SAMPLES);
   localparam logic [63:0] TS_STEP      = 64'(TIMESTAMP_ACCURACY);
   localparam logic [1:0]  CHANNEL_BITS = 2'(CHANNEL_ID);

   state_t      state_reg, state_next;
   logic [11:0] seq_reg, seq_next;
   logic [63:0] ts_reg, ts_next;
   logic [9:0]  count_reg, count_next;
   logic        ovf_reg, ovf_next;
   logic        err_reg, err_next;
   logic        push_reg, push_next;
   logic [31:0] data_reg, data_next;
   logic        led_reg, led_next;
   logic [15:0] drop_reg, drop_next;
   logic [15:0] errc_reg, errc_next;
   logic [15:0] fcs_low;
   logic [31:0] hdr_word;
   logic        hdr_slot;

`ifdef RX_FRAMER_CRC_EN
   logic [15:0] crc_reg, crc_next, crc_step;

   crc16_d32 u_crc (
      .crc_in  (crc_reg),
      .data    (i_data),
      .crc_out (crc_step)
   );

   assign fcs_low = crc_reg;
`else
   assign fcs_low = {6'd0, NB_LEN};
`endif

   always_comb begin
      state_next = state_reg;
      seq_next   = seq_reg;
      ts_next    = ts_reg;
      count_next = count_reg;
      ovf_next   = ovf_reg;
      err_next   = err_reg;
      push_next  = 1'b0;
      data_next  = data_reg;
      led_next   = led_reg;
      drop_next  = drop_reg;
      errc_next  = errc_reg;
      hdr_slot   = 1'b0;
      hdr_word   = '0;
`ifdef RX_FRAMER_CRC_EN
      crc_next   = crc_reg;
`endif

      // Payload tags advance the timestamp whatever the framer is doing,
      // so the timestamp tracks the sample clock even across aborts.
      if (i_data_tag == TAG_PAYLOAD) begin
         ts_next = ts_reg + TS_STEP;
      end

      case (state_reg)
         ST_HEADER: hdr_slot = 1'b1;
         ST_TS_MSB: begin
            if (i_data_tag == TAG_TS_MSB && !i_fifo_full) begin
               push_next  = 1'b1;
               data_next  = ts_reg[63:32];
               state_next = ST_TS_LSB;
            end
         end
         ST_TS_LSB: begin
            if (i_data_tag == TAG_TS_LSB && !i_fifo_full) begin
               push_next  = 1'b1;
               data_next  = ts_reg[31:0];
               count_next = CNT_LAST;
`ifdef RX_FRAMER_CRC_EN
               crc_next   = CRC_INIT;
`endif
               state_next = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (i_data_tag == TAG_PAYLOAD) begin
               if (i_fifo_full) begin
                  ovf_next   = 1'b1;
                  drop_next  = (drop_reg == 16'hFFFF) ? drop_reg : drop_reg + 16'd1;
                  state_next = ST_HEADER;
               end else begin
                  push_next = 1'b1;
                  data_next = i_data;
`ifdef RX_FRAMER_CRC_EN
                  crc_next  = crc_step;
`endif
                  if (count_reg == 10'd0) begin
                     state_next = ST_FCS;
                  end else begin
                     count_next = count_reg - 10'd1;
                  end
               end
            end else if (i_data_tag == TAG_HEADER) begin
               // Early header: abandon the frame and treat this slot as a header.
               err_next   = 1'b1;
               errc_next  = (errc_reg == 16'hFFFF) ? errc_reg : errc_reg + 16'd1;
               state_next = ST_HEADER;
               hdr_slot   = 1'b1;
            end
         end
         ST_FCS: begin
            if (i_data_tag == TAG_FCS && !i_fifo_full) begin
               push_next  = 1'b1;
               data_next  = {FCS_WORD, fcs_low};
               led_next   = ~led_reg;
               state_next = ST_HEADER;
            end
         end
         default: state_next = ST_HEADER;
      endcase

      // Header carries the flags as they stand after this slot's abort handling.
      hdr_word[HDR_SYNC_LSB +: 16]         = SYNC_WORD;
      hdr_word[HDR_OVF_BIT]                = ovf_next;
      hdr_word[HDR_ERR_BIT]                = err_next;
      hdr_word[HDR_CH_LSB +: 2]            = CHANNEL_BITS;
      hdr_word[HDR_SEQ_LSB +: HDR_SEQ_W]   = seq_reg;

      if (hdr_slot && i_data_tag == TAG_HEADER && i_enable && !i_fifo_full) begin
         push_next  = 1'b1;
         data_next  = hdr_word;
         seq_next   = seq_reg + 12'd1;
         ovf_next   = 1'b0;
         err_next   = 1'b0;
         state_next = ST_TS_MSB;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg <= ST_HEADER;
         seq_reg   <= '0;
         ts_reg    <= '0;
         count_reg <= CNT_LAST;
         ovf_reg   <= 1'b0;
         err_reg   <= 1'b0;
         push_reg  <= 1'b0;
         data_reg  <= '0;
         led_reg   <= 1'b0;
         drop_reg  <= '0;
         errc_reg  <= '0;
`ifdef RX_FRAMER_CRC_EN
         crc_reg   <= CRC_INIT;
`endif
      end else begin
         state_reg <= state_next;
         seq_reg   <= seq_next;
         ts_reg    <= ts_next;
         count_reg <= count_next;
         ovf_reg   <= ovf_next;
         err_reg   <= err_next;
         push_reg  <= push_next;
         data_reg  <= data_next;
         led_reg   <= led_next;
         drop_reg  <= drop_next;
         errc_reg  <= errc_next;
`ifdef RX_FRAMER_CRC_EN
         crc_reg   <= crc_next;
`endif
      end
   end

   assign o_fifo_push = push_reg;
   assign o_fifo_data = data_reg;
   assign o_led       = led_reg;
   assign o_busy      = (state_reg != ST_HEADER);
   assign o_drop_cnt  = drop_reg;
   assign o_err_cnt   = errc_reg;

endmodule
